alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit accumulator-style ALU for the matrix-multiplication processor core.
- aluIn1 carries the accumulator (AC); aluIn2 carries the second operand (memory/register bus).
- Computes one of eight operations selected by a 3-bit opcode.
- Registers the result and a zero flag on the rising clock edge; the control unit uses z for loop/branch decisions.

Parameters:
- WIDTH, 16, data width of operands and result; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- aluIn1  input  WIDTH  operand A, the accumulator (AC).
- aluIn2  input  WIDTH  operand B.
- aluOp  input  3  operation select.
- aluOut  output  WIDTH  registered result.
- z  output  1  registered zero flag; 1 when the registered result is zero.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, aluOut=0 and z=1, forced immediately without waiting for a clock edge. After release, the first rising edge loads normally.
- Latency: operands and aluOp are sampled at a rising edge. The result appears on aluOut and z after that edge, so latency is 1 cycle. The outputs hold until the next edge.
- There is no enable or handshake: a new operation is computed every cycle. Throughput is 1 operation per cycle.
- Opcodes (A=aluIn1, B=aluIn2), all results truncated to WIDTH bits:
  - 0 LOAD: B
  - 1 ADD: A+B, carry discarded
  - 2 SUB: A-B, two's-complement wrap on borrow
  - 3 MUL: A*B, low WIDTH bits of the 2*WIDTH product
  - 4 DEC: A-1 (0 wraps to all-ones)
  - 5 INC: A+1 (all-ones wraps to 0)
  - 6 PASS: A
  - 7 CLR: 0
- Zero flag: z is registered on the same edge as aluOut. z = (next aluOut == 0), evaluated on the truncated result, so wrap-to-zero sets z=1.
- No carry, overflow or sign outputs.
- Operands are unsigned. SUB and DEC wrap silently.
- The MUL product width is 2*WIDTH internally; only the low half is used. MUL must complete within the single cycle and is combinational before the register.
- Opcode set is fully decoded: all 8 codes are defined, and there is no illegal-opcode behaviour.
- X or unknown inputs need not be handled specially.
- Reset asserted mid-operation: outputs go to 0 / z=1 asynchronously. The in-flight result is discarded.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> aluOut=0 and z=1 immediately. Release, apply A=63, B=47, op=6 -> after the next edge aluOut=63, z=0.
- Opcode sweep with A=63, B=47, one op per cycle, checking each result one cycle after the op is applied:
  - op1 -> 110
  - op2 -> 16
  - op3 -> 2961
  - op4 -> 62
  - op5 -> 64
  - op6 -> 63
  - op7 -> 0 with z=1
  - op0 -> 47
  - z=0 for every op except op7.
- Counter/zero flag:
  - A=2, op=4 -> aluOut=1, z=0.
  - Next cycle A=1, op=4 -> aluOut=0, z=1.
  - Next cycle A=1, B=47, op=0 -> aluOut=47, z=0.
- Wrap-around:
  - A=0xFFFF, B=1, op=1 -> 0x0000, z=1.
  - A=47, B=63, op=2 -> 0xFFF0.
  - A=0, op=4 -> 0xFFFF.
  - A=0xFFFF, op=5 -> 0x0000, z=1.
  - A=300, B=300, op=3 -> 24464 (90000 mod 65536).
- Random regression: for each of ≥200 cycles, increment A by 1 and B by 10, randomize op. Compare aluOut/z against a reference model delayed by one cycle, including back-to-back opcode changes every cycle.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the control unit (master) and the
// accumulator ALU (slave).
interface alu_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] aluIn1;
  logic [WIDTH-1:0] aluIn2;
  logic [2:0]       aluOp;
  logic [WIDTH-1:0] aluOut;
  logic             z;

  modport master (
    output aluIn1,
    output aluIn2,
    output aluOp,
    input  aluOut,
    input  z
  );

  modport slave (
    input  aluIn1,
    input  aluIn2,
    input  aluOp,
    output aluOut,
    output z
  );
endinterface

// File: rtl/alu.sv
// Accumulator-style ALU: one of eight operations on AC (aluIn1) and the bus
// operand (aluIn2), result and zero flag registered with one cycle latency.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  logic [WIDTH-1:0] mulLow_s;
  logic [WIDTH-1:0] result_s;
  logic             resultZero_s;
  logic [WIDTH-1:0] aluOut_r;
  logic             z_r;

  // Low half of the full product; a WIDTH-bit context keeps exactly those bits.
  assign mulLow_s = bus.aluIn1 * bus.aluIn2;

  // Opcode decode: next result, truncated modulo 2^WIDTH.
  always_comb begin
    result_s = ZERO_C;
    case (bus.aluOp)
      OP_LOAD: result_s = bus.aluIn2;
      OP_ADD:  result_s = bus.aluIn1 + bus.aluIn2;
      OP_SUB:  result_s = bus.aluIn1 - bus.aluIn2;
      OP_MUL:  result_s = mulLow_s;
      OP_DEC:  result_s = bus.aluIn1 - ONE_C;
      OP_INC:  result_s = bus.aluIn1 + ONE_C;
      OP_PASS: result_s = bus.aluIn1;
      OP_CLR:  result_s = ZERO_C;
      default: result_s = ZERO_C;
    endcase
  end

  // Zero detect on the truncated result so wrap-to-zero raises the flag.
  always_comb begin
    if (result_s == ZERO_C) begin
      resultZero_s = 1'b1;
    end else begin
      resultZero_s = 1'b0;
    end
  end

  // Result and flag registers; reset clears the result and flags it as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluOut_r <= ZERO_C;
      z_r      <= 1'b1;
    end else begin
      aluOut_r <= result_s;
      z_r      <= resultZero_s;
    end
  end

  assign bus.aluOut = aluOut_r;
  assign bus.z      = z_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations
// plus an arithmetic reference model compared every cycle.
module tb_alu;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;
  logic cmpEn;

  logic [WIDTH-1:0] expOut;
  logic             expZ;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result defined by the opcode table using plain integer arithmetic mod 2^16.
  function automatic logic [WIDTH-1:0] refAlu(input longint unsigned a,
                                              input longint unsigned b,
                                              input int op);
    longint unsigned r;
    case (op)
      0:       r = b;
      1:       r = a + b;
      2:       r = a + 64'd65536 - b;
      3:       r = a * b;
      4:       r = a + 64'd65535;
      5:       r = a + 64'd1;
      6:       r = a;
      default: r = 64'd0;
    endcase
    return WIDTH'(r % 64'd65536);
  endfunction

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned want);
    nChecks++;
    if (got != want) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference model: mirrors the observable contract (async clear, one-cycle result).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expOut <= '0;
      expZ   <= 1'b1;
    end else begin
      expOut <= refAlu(bus.aluIn1, bus.aluIn2, int'(bus.aluOp));
      expZ   <= (refAlu(bus.aluIn1, bus.aluIn2, int'(bus.aluOp)) == 16'd0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      check("model_out", bus.aluOut, expOut);
      check("model_z", bus.z, expZ);
    end
  end

  task automatic apply(input string name, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [2:0] op,
                       input logic [WIDTH-1:0] wantOut, input logic wantZ);
    @(negedge clk);
    bus.aluIn1 = a;
    bus.aluIn2 = b;
    bus.aluOp  = op;
    @(posedge clk);
    #2;
    check({name, "_out"}, bus.aluOut, wantOut);
    check({name, "_z"}, bus.z, wantZ);
    check({name, "_ref"}, expOut, wantOut);
  endtask

  initial begin
    nChecks    = 0;
    nFails     = 0;
    cmpEn      = 1'b0;
    rst_n      = 1'b0;
    bus.aluIn1 = '0;
    bus.aluIn2 = '0;
    bus.aluOp  = '0;

    repeat (2) @(posedge clk);
    #2;
    check("reset_out", bus.aluOut, 16'd0);
    check("reset_z", bus.z, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cmpEn = 1'b1;

    apply("post_reset_pass", 16'd63, 16'd47, 3'd6, 16'd63, 1'b0);

    // Reset asserted between edges must clear the outputs at once.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", bus.aluOut, 16'd0);
    check("async_reset_z", bus.z, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    apply("sweep_add",  16'd63, 16'd47, 3'd1, 16'd110,  1'b0);
    apply("sweep_sub",  16'd63, 16'd47, 3'd2, 16'd16,   1'b0);
    apply("sweep_mul",  16'd63, 16'd47, 3'd3, 16'd2961, 1'b0);
    apply("sweep_dec",  16'd63, 16'd47, 3'd4, 16'd62,   1'b0);
    apply("sweep_inc",  16'd63, 16'd47, 3'd5, 16'd64,   1'b0);
    apply("sweep_pass", 16'd63, 16'd47, 3'd6, 16'd63,   1'b0);
    apply("sweep_clr",  16'd63, 16'd47, 3'd7, 16'd0,    1'b1);
    apply("sweep_load", 16'd63, 16'd47, 3'd0, 16'd47,   1'b0);

    apply("cnt_dec2",   16'd2,  16'd47, 3'd4, 16'd1,  1'b0);
    apply("cnt_dec1",   16'd1,  16'd47, 3'd4, 16'd0,  1'b1);
    apply("cnt_load",   16'd1,  16'd47, 3'd0, 16'd47, 1'b0);

    apply("wrap_add",   16'hFFFF, 16'd1,   3'd1, 16'h0000, 1'b1);
    apply("wrap_sub",   16'd47,   16'd63,  3'd2, 16'hFFF0, 1'b0);
    apply("wrap_dec",   16'd0,    16'd0,   3'd4, 16'hFFFF, 1'b0);
    apply("wrap_inc",   16'hFFFF, 16'd0,   3'd5, 16'h0000, 1'b1);
    apply("wrap_mul",   16'd300,  16'd300, 3'd3, 16'd24464, 1'b0);

    // Regression: ramping operands, new random opcode every cycle.
    begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = 16'd65400;
      b = 16'd60000;
      for (int i = 0; i < 220; i++) begin
        @(negedge clk);
        a = a + 16'd1;
        b = b + 16'd10;
        bus.aluIn1 = a;
        bus.aluIn2 = b;
        bus.aluOp  = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clk);
    @(negedge clk);
    cmpEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
